elevator_car: RTL
=================

Name: elevator_car

Overview:
- Clocked model of the elevator cab and its door.
- Consumes the door-open / up-down commands from the target-floor stage.
- Produces the current floor and the door-open status, which that stage and the request controller watch.
- Enforces the physical interlocks: no motion with the door not fully closed, no door opening between floors, no travel past the end floors.

Parameters:
- NUM_FLOORS, 8: number of floors, 0..NUM_FLOORS-1; must be at most 8, because floor is 3 bits.
- TRAVEL_TICKS, 10: clk cycles to travel one floor; must be at least 1.
- DOOR_TICKS, 5: clk cycles for a full door open or close stroke; must be at least 1.

Ports:
- clk, input, 1: rising-edge clock (one tick = 100 ms).
- rst_n, input, 1: reset, asynchronous, active-low.
- door_open, input, 1: 1 = request door open/held open; 0 = request door closed.
- updown, input, 2: 00 = stop, 01 = up, 10 = down, 11 = illegal (treated as stop).
- door, output, 1: 1 only while the door is fully open.
- floor, output, 3: current floor, updated at a floor boundary.
- moving, output, 1: 1 while the cab is in UP or DOWN.
- cmd_err, output, 1: one-cycle pulse on an illegal or interlocked command.

Behaviour:
- Reset (async assert, synchronous-release semantics on the next clk):
  - state = CLOSED, floor = 0, door = 0, moving = 0, cmd_err = 0, all counters 0.
  - Reset mid-travel or mid-door-stroke abandons the operation; the cab jumps to floor 0 (model cab).
- States: CLOSED, OPENING, OPEN, CLOSING, UP, DOWN. One counter (cnt) is shared by travel and door strokes.
- All outputs are registered. door = (state == OPEN); moving = (state == UP or DOWN).
- CLOSED, evaluated in this priority order:
  1. door_open = 1: go to OPENING, cnt = 0.
  2. updown = 01 and floor < NUM_FLOORS-1: go to UP, cnt = 0.
  3. updown = 10 and floor > 0: go to DOWN, cnt = 0.
  4. updown = 01 at the top floor, 10 at floor 0, or 11 anywhere: stay in CLOSED, pulse cmd_err.
  5. Otherwise stay in CLOSED.
- UP / DOWN:
  - cnt increments each cycle.
  - When cnt = TRAVEL_TICKS-1: floor ±1 in that cycle, state goes to CLOSED, cnt = 0.
  - The cab therefore always spends at least one cycle in CLOSED at each floor, so a door_open raised on seeing the new floor is honoured before the next floor.
  - Travel is committed: updown and door_open changes mid-floor are ignored until the boundary. door_open = 1 mid-travel does not pulse cmd_err.
  - floor never wraps. Saturation is enforced by the CLOSED guards, so floor stays within 0..NUM_FLOORS-1.
- OPENING:
  - cnt increments; at cnt = DOOR_TICKS-1 go to OPEN.
  - door_open dropping during OPENING: finish the stroke, then handle it in OPEN.
- OPEN:
  - door = 1.
  - Held while door_open = 1, whatever updown is.
  - updown ≠ 00 while in OPEN: cmd_err pulses once, on the first cycle that updown becomes non-zero; it is then ignored.
  - door_open = 0: go to CLOSING, cnt = 0; door falls to 0 in that same edge.
- CLOSING:
  - cnt increments; at cnt = DOOR_TICKS-1 go to CLOSED.
  - door_open = 1 during CLOSING (reopen): go to OPENING, cnt = 0.
- Latencies:
  - Door request to door = 1: DOOR_TICKS+1 cycles from CLOSED.
  - Motion request to floor change: TRAVEL_TICKS+1 cycles.
  - Floor-to-floor when updown is held: TRAVEL_TICKS+1 cycles, including the CLOSED cycle.
- Simultaneous events:
  - door_open and updown both active in CLOSED: door wins.
  - The reset edge overrides everything.

Test Plan (TRAVEL_TICKS = 4, DOOR_TICKS = 2):
- Reset, then updown = 01 held from floor 0: floor reads 1, 2, 3 at cycles 5, 10, 15 after the request, with moving = 1 except in the CLOSED cycles; at floor 7 the cab stays put and cmd_err pulses once per CLOSED cycle.
- At floor 2 going up, door_open = 1 on the cycle after floor becomes 2, updown still 01: no departure; door = 1 three cycles later; moving = 0.
- Door open at floor 3, updown = 10, door_open dropped: door = 0 next cycle; CLOSING takes 2 cycles, 1 cycle in CLOSED, then DOWN; floor = 2 five cycles later.
- During CLOSING (cnt = 0), door_open = 1 again: state goes to OPENING; door = 1 after 2 more cycles; floor unchanged.
- updown = 11 in CLOSED at floor 4: no motion, cmd_err = 1 for exactly one cycle, floor = 4.
- Mid-travel from floor 5 to 6 (cnt = 2), rst_n pulsed low: floor = 0, door = 0, moving = 0 immediately (asynchronously); normal operation resumes after release.

Source files
------------

// File: rtl/elevator_car_if.sv
// Command/status bundle between the target-floor stage (master) and the cab model (slave).
interface elevator_car_if;
  logic       door_open;
  logic [1:0] updown;
  logic       door;
  logic [2:0] floor;
  logic       moving;
  logic       cmd_err;

  modport master (
    output door_open, updown,
    input  door, floor, moving, cmd_err
  );

  modport slave (
    input  door_open, updown,
    output door, floor, moving, cmd_err
  );
endinterface

// File: rtl/elevator_car.sv
// Elevator cab and door model with motion/door interlocks and end-floor saturation.
// One shared counter times both floor travel and door strokes.
module elevator_car #(
  parameter int NUM_FLOORS   = 8,
  parameter int TRAVEL_TICKS = 10,
  parameter int DOOR_TICKS   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  elevator_car_if.slave    bus,
  output logic [2:0]       dbg_state_o
);

  localparam int CNT_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);
  localparam logic [2:0]       TOP_FLOOR   = 3'(NUM_FLOORS - 1);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_UP      = 3'd4,
    S_DOWN    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       floor_q, floor_d;
  logic             cmd_err_q, cmd_err_d;
  logic             ud_seen_q, ud_seen_d;

  // Commands are level-sensitive and sampled every clk; there is no valid/ready
  // handshake, the stage simply holds door_open/updown until it sees the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLOSED;
      cnt_q     <= '0;
      floor_q   <= 3'd0;
      cmd_err_q <= 1'b0;
      ud_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      floor_q   <= floor_d;
      cmd_err_q <= cmd_err_d;
      ud_seen_q <= ud_seen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    floor_d   = floor_q;
    cmd_err_d = 1'b0;
    ud_seen_d = ud_seen_q;
    unique case (state_q)
      S_CLOSED: begin
        ud_seen_d = 1'b0;
        if (bus.door_open) begin
          state_d = S_OPENING;
          cnt_d   = '0;
        end else if (bus.updown == 2'b01 && floor_q < TOP_FLOOR) begin
          state_d = S_UP;
          cnt_d   = '0;
        end else if (bus.updown == 2'b10 && floor_q != 3'd0) begin
          state_d = S_DOWN;
          cnt_d   = '0;
        end else if (bus.updown != 2'b00) begin
          cmd_err_d = 1'b1;
        end
      end
      S_UP, S_DOWN: begin
        // Travel is committed: inputs are ignored until the floor boundary.
        if (cnt_q == TRAVEL_LAST) begin
          floor_d = (state_q == S_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
          state_d = S_CLOSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OPENING: begin
        if (cnt_q == DOOR_LAST) begin
          state_d = S_OPEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OPEN: begin
        if (!bus.door_open) begin
          state_d   = S_CLOSING;
          cnt_d     = '0;
          ud_seen_d = 1'b0;
        end else if (bus.updown != 2'b00) begin
          // Flag a motion request against an open door only on its first cycle.
          cmd_err_d = !ud_seen_q;
          ud_seen_d = 1'b1;
        end else begin
          ud_seen_d = 1'b0;
        end
      end
      S_CLOSING: begin
        if (bus.door_open) begin
          state_d = S_OPENING;
          cnt_d   = '0;
        end else if (cnt_q == DOOR_LAST) begin
          state_d = S_CLOSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_CLOSED;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.door     = (state_q == S_OPEN);
  assign bus.moving   = (state_q == S_UP) || (state_q == S_DOWN);
  assign bus.floor    = floor_q;
  assign bus.cmd_err  = cmd_err_q;
  assign dbg_state_o  = state_q;

endmodule
